// File: rtl/hdl_decoder_2to4_seq_pkg.sv
// Shared encodings and sizing for the sequenced 2-to-4 decoder and its input FIFO.
package hdl_decoder_2to4_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 4;

  function automatic logic [3:0] decode_onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/hdl_fifo_2x2.sv
// Two-entry, two-bit FIFO; entry 0 is always the head so pop is a simple shift.
module hdl_fifo_2x2
  import hdl_decoder_2to4_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [1:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [1:0] head
);

  logic [1:0] occ_q, occ_d, occ_pop;
  logic [1:0] mem_q [FIFO_DEPTH];
  logic [1:0] mem_d [FIFO_DEPTH];

  assign full  = (occ_q == 2'(FIFO_DEPTH));
  assign empty = (occ_q == 2'd0);
  assign head  = mem_q[0];

  // Pop first, then push into the slot just past the post-pop occupancy,
  // which keeps order intact when both happen with one entry held.
  always_comb begin
    mem_d   = mem_q;
    occ_pop = occ_q;
    if (pop && !empty) begin
      mem_d[0] = mem_q[1];
      occ_pop  = occ_q - 2'd1;
    end
    occ_d = occ_pop;
    if (push && !full) begin
      mem_d[occ_pop[0]] = push_data;
      occ_d             = occ_pop + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q    <= 2'd0;
      mem_q[0] <= 2'd0;
      mem_q[1] <= 2'd0;
    end else begin
      occ_q    <= occ_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

endmodule

// File: rtl/hdl_decoder_2to4_seq.sv
// Buffered 2-to-4 decoder: each accepted code drives its one-hot output for
// HOLD_CYCLES cycles, followed by a one-cycle all-zero gap flagged by done.
module hdl_decoder_2to4_seq
  import hdl_decoder_2to4_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic A0,
  input  logic A1,
  output logic D0,
  output logic D1,
  output logic D2,
  output logic D3,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       code_q, code_d;
  logic [3:0]       d_q, d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       push, pop;
  logic       fifo_full, fifo_empty;
  logic [1:0] fifo_head;
  logic [1:0] occ, occ_next;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  hdl_fifo_2x2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({A1, A0}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          code_d  = fifo_head;
          cnt_d   = HOLD_LOAD;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
        else             state_d = ST_GAP;
      end
      ST_GAP: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          code_d  = fifo_head;
          cnt_d   = HOLD_LOAD;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it.
    occ      = {fifo_full, !fifo_full && !fifo_empty};
    occ_next = occ + {1'b0, push} - {1'b0, pop};
    d_d      = (state_d == ST_DRIVE) ? decode_onehot(code_d) : 4'b0000;
    done_d   = (state_d == ST_GAP);
    busy_d   = (state_d != ST_IDLE) || (occ_next != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= 2'd0;
      d_q     <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {D3, D2, D1, D0} = d_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_hdl_decoder_2to4_seq.sv
// Two instances (HOLD_CYCLES=4 and 1) checked against a per-code schedule model.
module tb_hdl_decoder_2to4_seq;
  localparam int H0 = 4;
  localparam int H1 = 1;
  localparam int MAXC = 512;

  logic clk, rst;
  logic iv [2];
  logic [1:0] ia [2];
  wire  ir0, ir1, bz0, bz1, dn0, dn1;
  wire  [3:0] dq0, dq1;

  hdl_decoder_2to4_seq #(.HOLD_CYCLES(H0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .A0(ia[0][0]), .A1(ia[0][1]),
    .D0(dq0[0]), .D1(dq0[1]), .D2(dq0[2]), .D3(dq0[3]), .busy(bz0), .done(dn0));
  hdl_decoder_2to4_seq #(.HOLD_CYCLES(H1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .A0(ia[1][0]), .A1(ia[1][1]),
    .D0(dq1[0]), .D1(dq1[1]), .D2(dq1[2]), .D3(dq1[3]), .busy(bz1), .done(dn1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc;
  // Schedule model: per accepted code, the edge it was accepted and the edge it starts driving.
  int acc_t [2][MAXC];
  int st_t  [2][MAXC];
  logic [1:0] cd [2][MAXC];
  int n [2];
  logic accepted [2];
  logic prev_done [2];

  function automatic int hold(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  function automatic int occ(input int i, input int c);
    int k, s;
    s = 0;
    for (k = 0; k < n[i]; k++) if (acc_t[i][k] <= c && st_t[i][k] > c) s++;
    return s;
  endfunction

  function automatic logic [3:0] exp_d(input int i, input int c);
    int k;
    logic [3:0] r;
    r = 4'b0000;
    for (k = 0; k < n[i]; k++)
      if (st_t[i][k] <= c && c < st_t[i][k] + hold(i)) r = 4'b0001 << cd[i][k];
    return r;
  endfunction

  function automatic logic exp_done(input int i, input int c);
    int k;
    logic r;
    r = 1'b0;
    for (k = 0; k < n[i]; k++) if (c == st_t[i][k] + hold(i)) r = 1'b1;
    return r;
  endfunction

  function automatic logic exp_busy(input int i, input int c);
    int k;
    logic r;
    r = 1'b0;
    for (k = 0; k < n[i]; k++) if (acc_t[i][k] <= c && c <= st_t[i][k] + hold(i)) r = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic model_reset();
    n[0] = 0; n[1] = 0;
    prev_done[0] = 1'b0; prev_done[1] = 1'b0;
    cyc = 0;
  endtask

  task automatic check_outputs();
    logic [3:0] d;
    logic b, dn;
    for (int i = 0; i < 2; i++) begin
      d  = (i == 0) ? dq0 : dq1;
      b  = (i == 0) ? bz0 : bz1;
      dn = (i == 0) ? dn0 : dn1;
      chk($sformatf("d%0d", i), {28'd0, d}, {28'd0, exp_d(i, cyc)});
      chk($sformatf("done%0d", i), {31'd0, dn}, {31'd0, exp_done(i, cyc)});
      chk($sformatf("busy%0d", i), {31'd0, b}, {31'd0, exp_busy(i, cyc)});
      chk($sformatf("onehot%0d", i), {31'd0, ($countones(d) <= 1)}, 32'd1);
      chk($sformatf("done_twice%0d", i), {31'd0, (prev_done[i] && dn)}, 32'd0);
      prev_done[i] = dn;
    end
  endtask

  // Called at a negedge with iv/ia set; advances one clock edge and checks.
  task automatic step();
    logic rdy, obs_rdy;
    int s;
    for (int i = 0; i < 2; i++) begin
      rdy     = (occ(i, cyc) < 2);
      obs_rdy = (i == 0) ? ir0 : ir1;
      chk($sformatf("ready%0d", i), {31'd0, obs_rdy}, {31'd0, rdy});
      accepted[i] = iv[i] && rdy;
      if (accepted[i] && n[i] < MAXC) begin
        s = cyc + 2;
        if (n[i] > 0 && st_t[i][n[i]-1] + hold(i) + 1 > s) s = st_t[i][n[i]-1] + hold(i) + 1;
        acc_t[i][n[i]] = cyc + 1;
        st_t[i][n[i]]  = s;
        cd[i][n[i]]    = ia[i];
        n[i]++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int k);
    iv[0] = 1'b0; iv[1] = 1'b0;
    repeat (k) step();
  endtask

  initial begin
    int idx0, idx1, guard;
    logic [1:0] seq1 [2];
    seq1[0] = 2'b11; seq1[1] = 2'b01;
    rst = 1'b1;
    iv[0] = 1'b0; iv[1] = 1'b0; ia[0] = 2'b00; ia[1] = 2'b00;
    accepted[0] = 1'b0; accepted[1] = 1'b0;
    model_reset();

    #3;
    chk("rst_d0", {28'd0, dq0}, 32'd0);
    chk("rst_d1", {28'd0, dq1}, 32'd0);
    chk("rst_busy", {30'd0, bz0, bz1}, 32'd0);
    chk("rst_done", {30'd0, dn0, dn1}, 32'd0);
    chk("rst_ready", {30'd0, ir0, ir1}, 32'd3);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single code 10 on the HOLD=4 instance.
    iv[0] = 1'b1; ia[0] = 2'b10;
    step();
    idle(8);

    // Back-to-back 00..11 on inst0, 11 then 01 on inst1, valid held until accepted.
    idx0 = 0; idx1 = 0; guard = 0;
    while ((idx0 < 4 || idx1 < 2) && guard < 60) begin
      iv[0] = (idx0 < 4); ia[0] = 2'(idx0);
      iv[1] = (idx1 < 2); ia[1] = seq1[idx1 < 2 ? idx1 : 0];
      step();
      if (accepted[0]) idx0++;
      if (accepted[1]) idx1++;
      guard++;
    end
    chk("b2b_accepted", 32'(idx0 * 10 + idx1), 32'd42);
    idle(24);

    // Push with one entry held on the same edge that entry is popped.
    iv[0] = 1'b1; ia[0] = 2'b01; step();
    iv[0] = 1'b0; step();
    iv[0] = 1'b1; ia[0] = 2'b11; step();
    iv[0] = 1'b0; repeat (3) step();
    iv[0] = 1'b1; ia[0] = 2'b00; step();
    chk("pushpop_accept", {31'd0, accepted[0]}, 32'd1);
    idle(18);

    // Reset between edges during the 2nd cycle of D1, with 10 still buffered.
    idx0 = 0; guard = 0;
    while (idx0 < 3 && guard < 30) begin
      iv[0] = 1'b1; ia[0] = 2'(idx0);
      step();
      if (accepted[0]) idx0++;
      guard++;
    end
    iv[0] = 1'b0;
    guard = 0;
    while (exp_d(0, cyc) != 4'b0010 && guard < 30) begin step(); guard++; end
    chk("reach_d1", {28'd0, dq0}, 32'd2);
    step();
    chk("d1_second", {28'd0, dq0}, 32'd2);
    chk("buffered", 32'(occ(0, cyc)), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_d", {28'd0, dq0}, 32'd0);
    chk("arst_done", {31'd0, dn0}, 32'd0);
    chk("arst_busy", {31'd0, bz0}, 32'd0);
    chk("arst_ready", {31'd0, ir0}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(12);

    // Random traffic on both instances.
    for (int t = 0; t < 300; t++) begin
      iv[0] = 1'($urandom_range(0, 1)); ia[0] = 2'($urandom_range(0, 3));
      iv[1] = 1'($urandom_range(0, 1)); ia[1] = 2'($urandom_range(0, 3));
      step();
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
